streamlined_divider: RTL and testbench

STREAMLINED_DIVIDER -- requirements
Module: streamlined_divider

---
 rtl/streamlined_divider_pkg.sv | 6 +
 rtl/divider_step.sv | 19 +
 rtl/streamlined_divider.sv | 60 ++++++
 tb/tb_streamlined_divider.sv | 134 +++++++++++++
 4 files changed

// File: rtl/streamlined_divider_pkg.sv
// streamlined_divider_pkg: shared width constants and FSM state type for the divider
package streamlined_divider_pkg;
  localparam int WIDTH_DEF = 8;
  localparam int CNT_W = $clog2(WIDTH_DEF + 1);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
endpackage

// File: rtl/divider_step.sv
// divider_step: one combinational restoring-division step (shift, compare, subtract, quotient bit)
module divider_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] dvd,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_nxt,
  output logic [WIDTH-1:0] dvd_nxt
);
  logic [WIDTH:0] sh, diff;
  logic q;
  assign sh = {rem, dvd[WIDTH-1]};
  assign diff = sh - {1'b0, dvs};
  assign q = sh >= {1'b0, dvs};
  assign rem_nxt = q ? diff[WIDTH-1:0] : sh[WIDTH-1:0];
  // dividend register doubles as the quotient shift register
  assign dvd_nxt = {dvd[WIDTH-2:0], q};
endmodule

// File: rtl/streamlined_divider.sv
// streamlined_divider: multi-cycle unsigned restoring divider, one quotient bit per cycle
module streamlined_divider
  import streamlined_divider_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] divisor,
  input  logic [WIDTH-1:0] dividend,
  input  logic             start_sig,
  output logic             done_sig,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Reminder
);
  localparam int CW = $clog2(WIDTH + 1);
  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] rem, dvd, dvs, rem_nxt, dvd_nxt;
  logic last;
  divider_step #(.WIDTH(WIDTH)) u_step (
    .rem(rem), .dvd(dvd), .dvs(dvs), .rem_nxt(rem_nxt), .dvd_nxt(dvd_nxt)
  );
  assign last = cnt == CW'(WIDTH - 1);
  always_comb begin
    state_nxt = IDLE;
    state_nxt = state == IDLE ? (start_sig ? CALC : IDLE) :
                state == CALC ? (last ? DONE : CALC) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      rem <= '0;
      dvd <= '0;
      dvs <= '0;
      done_sig <= 1'b0;
      Quotient <= '0;
      Reminder <= '0;
    end else begin
      state <= state_nxt;
      done_sig <= state == CALC && last;
      if (state == IDLE && start_sig) begin
        dvd <= dividend;
        dvs <= divisor;
        rem <= '0;
        cnt <= '0;
      end
      if (state == CALC) begin
        rem <= rem_nxt;
        dvd <= dvd_nxt;
        cnt <= cnt + 1'b1;
        if (last) begin
          Quotient <= dvd_nxt;
          Reminder <= rem_nxt;
        end
      end
    end
  end
endmodule

// File: tb/tb_streamlined_divider.sv
// tb_streamlined_divider: directed vector table plus corner-case sequences for streamlined_divider
module tb_streamlined_divider;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start_sig = 1'b0;
  logic [W-1:0] dividend = '0, divisor = '0;
  logic done_sig;
  logic [W-1:0] Quotient, Reminder;
  int checks = 0, failures = 0;

  streamlined_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .divisor(divisor), .dividend(dividend),
    .start_sig(start_sig), .done_sig(done_sig), .Quotient(Quotient), .Reminder(Reminder)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a, b, q, r;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic wait_done(input bit mess, output int lat);
    lat = -1;
    for (int k = 1; k <= W + 4; k++) begin
      @(posedge clk); #1;
      if (done_sig) begin
        lat = k;
        break;
      end
      if (mess) begin
        dividend = W'($urandom);
        divisor = W'($urandom);
        start_sig = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic run(input logic [W-1:0] a, b, q, r, input bit mess, input string nm);
    int lat;
    dividend = a;
    divisor = b;
    start_sig = 1'b1;
    @(posedge clk); #1;
    wait_done(mess, lat);
    start_sig = 1'b0;
    chk({nm, " latency"}, lat, W);
    chk({nm, " quotient"}, int'(Quotient), int'(q));
    chk({nm, " remainder"}, int'(Reminder), int'(r));
    @(posedge clk); #1;
    chk({nm, " done width"}, int'(done_sig), 0);
    chk({nm, " quotient hold"}, int'(Quotient), int'(q));
  endtask

  initial begin
    int lat;
    bit seen;
    logic [W-1:0] a, b, ea, eb;
    vecs[0] = '{8'd243, 8'd10, 8'd24, 8'd3};
    vecs[1] = '{8'd255, 8'd1, 8'd255, 8'd0};
    vecs[2] = '{8'd7, 8'd9, 8'd0, 8'd7};
    vecs[3] = '{8'd100, 8'd0, 8'd255, 8'd100};
    vecs[4] = '{8'd255, 8'd255, 8'd1, 8'd0};
    vecs[5] = '{8'd128, 8'd3, 8'd42, 8'd2};

    #1 rst_n = 1'b0;
    #1;
    chk("reset done", int'(done_sig), 0);
    chk("reset quotient", int'(Quotient), 0);
    chk("reset remainder", int'(Reminder), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1;

    for (int i = 0; i < 6; i++)
      run(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, 1'b0, $sformatf("vec%0d", i));

    run(8'd200, 8'd7, 8'd28, 8'd4, 1'b1, "ignore_inputs");

    dividend = 8'd200;
    divisor = 8'd7;
    start_sig = 1'b1;
    @(posedge clk); #1;
    start_sig = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort quotient", int'(Quotient), 0);
    chk("abort remainder", int'(Reminder), 0);
    chk("abort done", int'(done_sig), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    seen = 1'b0;
    repeat (W + 4) begin
      @(posedge clk); #1;
      if (done_sig) seen = 1'b1;
    end
    chk("no done after abort", int'(seen), 0);
    chk("abort outputs stay zero", int'(Quotient), 0);
    run(8'd50, 8'd5, 8'd10, 8'd0, 1'b0, "post_reset");

    a = 8'd0; b = 8'd0;
    dividend = a;
    divisor = b;
    start_sig = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 40; i++) begin
      ea = (b == 0) ? '1 : a / b;
      eb = (b == 0) ? a : a % b;
      wait_done(1'b0, lat);
      chk($sformatf("sweep%0d latency", i), lat, i == 0 ? W : W + 2);
      chk($sformatf("sweep%0d q %0d/%0d", i, a, b), int'(Quotient), int'(ea));
      chk($sformatf("sweep%0d r %0d%%%0d", i, a, b), int'(Reminder), int'(eb));
      a = (i == 0) ? 8'd0 : (i == 1) ? 8'd255 : W'($urandom);
      b = (i == 0) ? 8'd1 : (i == 1) ? 8'd255 : (i % 7 == 0) ? 8'd0 : W'($urandom);
      dividend = a;
      divisor = b;
    end
    start_sig = 1'b0;
    repeat (W + 4) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
